// File: rtl/ldpc_cw_serializer_if.sv
// Handshake bundle between the LDPC encoder output, the serializer and the modulator input.
// The slave modport is the serializer side; the master modport is the source/sink side.
interface ldpc_cw_serializer_if;
    logic         msg_valid;
    logic [26:0]  msg_data;
    logic         msg_ready;
    logic         par_valid;
    logic [161:0] par_data;
    logic         cw_valid;
    logic         cw_ready;
    logic [26:0]  cw_data;
    logic         cw_sop;
    logic         cw_eop;
    logic         err_ovf;
    logic         err_short;

    modport master (
        output msg_valid, msg_data, par_valid, par_data, cw_ready,
        input  msg_ready, cw_valid, cw_data, cw_sop, cw_eop, err_ovf, err_short
    );

    modport slave (
        input  msg_valid, msg_data, par_valid, par_data, cw_ready,
        output msg_ready, cw_valid, cw_data, cw_sop, cw_eop, err_ovf, err_short
    );
endinterface

// File: rtl/ldpc_cw_serializer.sv
// Systematic codeword assembler for the 648-bit Z=27 rate-3/4 LDPC code: message words, then six parity words.
// Define LDPC_SER_ERR_EN to build the sticky err_ovf / err_short flags; otherwise they are tied low.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no codeword in progress, waiting for message word 0
// COLLECT  | storing message words 1..MSG_WORDS-1
// WAIT_PAR | full message held, waiting for the encoder parity strobe
// SEND     | streaming word cnt (message words, then parity words)
module ldpc_cw_serializer #(
    parameter int MSG_WORDS = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    ldpc_cw_serializer_if.slave  bus
);
    localparam int CW = $clog2(MSG_WORDS + 6);
    localparam logic [CW-1:0] MSG_C  = CW'(MSG_WORDS);
    localparam logic [CW-1:0] LAST_C = CW'(MSG_WORDS + 5);

    typedef enum logic [1:0] {IDLE, COLLECT, WAIT_PAR, SEND} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next, nxt_idx, wr_idx;
    logic [26:0]     msg_buf [MSG_WORDS];
    logic [161:0]    par_buf;
    logic [26:0]     next_word;
    logic            msg_wr, take, par_take;

    logic [26:0]     data_q, data_d;
    logic            valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;

    assign take     = valid_q && bus.cw_ready;
    assign par_take = (state == WAIT_PAR) && bus.par_valid;
    // A parity strobe during COLLECT aborts the message, so the coincident word is not stored.
    assign msg_wr   = bus.msg_valid &&
                      ((state == IDLE) || ((state == COLLECT) && !bus.par_valid));
    assign wr_idx   = (state == IDLE) ? '0 : cnt;
    assign nxt_idx  = cnt + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.msg_valid) begin
                    cnt_next   = CW'(1);
                    state_next = (MSG_WORDS == 1) ? WAIT_PAR : COLLECT;
                end
            end
            COLLECT: begin
                if (bus.par_valid) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (bus.msg_valid) begin
                    cnt_next = nxt_idx;
                    if (nxt_idx == MSG_C) state_next = WAIT_PAR;
                end
            end
            WAIT_PAR: begin
                if (bus.par_valid) begin
                    state_next = SEND;
                    cnt_next   = '0;
                end
            end
            SEND: begin
                if (take) begin
                    if (cnt == LAST_C) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = nxt_idx;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Word that follows the one currently on cw_data; parity words run p1 first, lowest bits last.
    always_comb begin
        next_word = '0;
        for (int i = 0; i < MSG_WORDS; i++)
            if (nxt_idx == CW'(i)) next_word = msg_buf[i];
        for (int j = 0; j < 6; j++)
            if (nxt_idx == CW'(MSG_WORDS + j)) next_word = par_buf[27*(5-j) +: 27];
    end

    always_comb begin
        valid_d = (state_next == SEND);
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (par_take) begin
            data_d = msg_buf[0];
            sop_d  = 1'b1;
            eop_d  = 1'b0;
        end else if (take) begin
            if (cnt == LAST_C) begin
                data_d = '0;
                sop_d  = 1'b0;
                eop_d  = 1'b0;
            end else begin
                data_d = next_word;
                sop_d  = 1'b0;
                eop_d  = (nxt_idx == LAST_C);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MSG_WORDS; i++)
            if (msg_wr && (wr_idx == CW'(i))) msg_buf[i] <= bus.msg_data;
        if (par_take) par_buf <= bus.par_data;
    end

    assign bus.msg_ready = (state == IDLE) || (state == COLLECT);
    assign bus.cw_valid  = valid_q;
    assign bus.cw_data   = data_q;
    assign bus.cw_sop    = sop_q;
    assign bus.cw_eop    = eop_q;

`ifdef LDPC_SER_ERR_EN
    logic ovf_q, short_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            if (bus.msg_valid && ((state == WAIT_PAR) || (state == SEND))) ovf_q <= 1'b1;
            if (bus.par_valid && (state == COLLECT)) short_q <= 1'b1;
        end
    end

    assign bus.err_ovf   = ovf_q;
    assign bus.err_short = short_q;
`else
    assign bus.err_ovf   = 1'b0;
    assign bus.err_short = 1'b0;
`endif

endmodule

// File: tb/tb_ldpc_cw_serializer.sv
// Directed bench for ldpc_cw_serializer at MSG_WORDS=18 (24-word codewords).
module tb_ldpc_cw_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

`ifdef LDPC_SER_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    ldpc_cw_serializer_if bus();
    ldpc_cw_serializer #(.MSG_WORDS(18)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    logic [26:0] got_w [24];
    logic        got_sop [24];
    logic        got_eop [24];
    logic [26:0] exp_w [24];
    int n_got, valid_cycles, stall_bad, cycles_used;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus.msg_valid = 1'b0;
        bus.par_valid = 1'b0;
        bus.msg_data  = '0;
        bus.par_data  = '0;
        bus.cw_ready  = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send_msg(input int n, input logic [26:0] base);
        for (int i = 0; i < n; i++) begin
            bus.msg_valid = 1'b1;
            bus.msg_data  = base + 27'(i);
            tick();
        end
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
    endtask

    task automatic pulse_par(input logic [161:0] p);
        bus.par_valid = 1'b1;
        bus.par_data  = p;
        tick();
        bus.par_valid = 1'b0;
        bus.par_data  = '0;
    endtask

    task automatic set_exp(input logic [26:0] base, input logic [161:0] p);
        for (int i = 0; i < 18; i++) exp_w[i] = base + 27'(i);
        for (int j = 0; j < 6; j++) exp_w[18+j] = p[27*(5-j) +: 27];
    endtask

    // mode 0: cw_ready always high; mode 1: cw_ready 1,0,0,1 repeating
    task automatic collect(input int mode);
        logic [26:0] hold_d;
        logic        hold_s, hold_e;
        bit          stalled;
        int          cyc;
        n_got = 0; valid_cycles = 0; stall_bad = 0; stalled = 0; cyc = 0;
        hold_d = '0; hold_s = 1'b0; hold_e = 1'b0;
        for (int i = 0; i < 24; i++) begin
            got_w[i] = 'x; got_sop[i] = 1'bx; got_eop[i] = 1'bx;
        end
        while (n_got < 24 && cyc < 300) begin
            bus.cw_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (stalled && (bus.cw_valid !== 1'b1 || bus.cw_data !== hold_d ||
                            bus.cw_sop !== hold_s || bus.cw_eop !== hold_e))
                stall_bad++;
            if (bus.cw_valid === 1'b1) begin
                valid_cycles++;
                if (bus.cw_ready) begin
                    got_w[n_got]   = bus.cw_data;
                    got_sop[n_got] = bus.cw_sop;
                    got_eop[n_got] = bus.cw_eop;
                    n_got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hold_d  = bus.cw_data;
                    hold_s  = bus.cw_sop;
                    hold_e  = bus.cw_eop;
                end
            end
            tick();
            cyc++;
        end
        cycles_used = cyc;
        bus.cw_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.msg_valid = 1'b0; bus.par_valid = 1'b0; bus.cw_ready = 1'b1;
        bus.msg_data = '0; bus.par_data = '0;
        #12;
        tests++; if (bus.cw_valid !== 1'b0) begin fails++; $display("FAIL reset_cw_valid got %b want 0", bus.cw_valid); end
        tests++; if (bus.cw_sop !== 1'b0 || bus.cw_eop !== 1'b0) begin fails++; $display("FAIL reset_sop_eop got %b%b want 00", bus.cw_sop, bus.cw_eop); end
        tests++; if (bus.cw_data !== 27'h0) begin fails++; $display("FAIL reset_cw_data got %h want 0", bus.cw_data); end
        tests++; if (bus.err_ovf !== 1'b0 || bus.err_short !== 1'b0) begin fails++; $display("FAIL reset_err got %b%b want 00", bus.err_ovf, bus.err_short); end
        tests++; if (bus.msg_ready !== 1'b1) begin fails++; $display("FAIL reset_msg_ready got %b want 1", bus.msg_ready); end
    endtask

    task automatic test_nominal();
        apply_reset();
        send_msg(18, 27'h1);
        repeat (6) tick();
        pulse_par(162'h1);
        tests++; if (bus.cw_valid !== 1'b1 || bus.cw_sop !== 1'b1 || bus.cw_data !== 27'h1) begin
            fails++; $display("FAIL nom_first_word got v=%b sop=%b d=%h want v=1 sop=1 d=1", bus.cw_valid, bus.cw_sop, bus.cw_data); end
        set_exp(27'h1, 162'h1);
        collect(0);
        tests++; if (n_got != 24) begin fails++; $display("FAIL nom_count got %0d want 24", n_got); end
        tests++; if (valid_cycles != 24 || cycles_used != 24) begin fails++; $display("FAIL nom_consecutive got valid=%0d cycles=%0d want 24/24", valid_cycles, cycles_used); end
        for (int i = 0; i < 24; i++) begin
            tests++; if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL nom_word%0d got %h want %h", i + 1, got_w[i], exp_w[i]); end
            tests++; if (got_sop[i] !== (i == 0) || got_eop[i] !== (i == 23)) begin
                fails++; $display("FAIL nom_sop_eop%0d got %b%b want %b%b", i + 1, got_sop[i], got_eop[i], i == 0, i == 23); end
        end
        tests++; if (bus.cw_valid !== 1'b0 || bus.msg_ready !== 1'b1) begin fails++; $display("FAIL nom_after_eop got v=%b rdy=%b want 0/1", bus.cw_valid, bus.msg_ready); end
        tests++; if (bus.err_ovf !== 1'b0 || bus.err_short !== 1'b0) begin fails++; $display("FAIL nom_err got %b%b want 00", bus.err_ovf, bus.err_short); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        send_msg(18, 27'h1);
        repeat (6) tick();
        pulse_par(162'h1);
        set_exp(27'h1, 162'h1);
        collect(1);
        tests++; if (n_got != 24) begin fails++; $display("FAIL bp_count got %0d want 24", n_got); end
        tests++; if (stall_bad != 0) begin fails++; $display("FAIL bp_stable got %0d unstable cycles want 0", stall_bad); end
        for (int i = 0; i < 24; i++) begin
            tests++; if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL bp_word%0d got %h want %h", i + 1, got_w[i], exp_w[i]); end
        end
        tests++; if (got_sop[0] !== 1'b1 || got_eop[23] !== 1'b1) begin fails++; $display("FAIL bp_sop_eop got %b%b want 11", got_sop[0], got_eop[23]); end
        tests++; if (bus.cw_valid !== 1'b0) begin fails++; $display("FAIL bp_after_eop got v=%b want 0", bus.cw_valid); end
    endtask

    task automatic test_parity_order();
        logic [161:0] p;
        p = {27'h5A5A5A5, 108'h0, 27'h2A2A2A2};
        apply_reset();
        send_msg(18, 27'h100);
        repeat (3) tick();
        pulse_par(p);
        collect(0);
        tests++; if (got_w[18] !== 27'h5A5A5A5) begin fails++; $display("FAIL par_word19 got %h want 5a5a5a5", got_w[18]); end
        tests++; if (got_w[23] !== 27'h2A2A2A2) begin fails++; $display("FAIL par_word24 got %h want 2a2a2a2", got_w[23]); end
        for (int i = 19; i < 23; i++) begin
            tests++; if (got_w[i] !== 27'h0) begin fails++; $display("FAIL par_word%0d got %h want 0", i + 1, got_w[i]); end
        end
        tests++; if (got_w[17] !== 27'h111) begin fails++; $display("FAIL par_word18 got %h want 111", got_w[17]); end
    endtask

    task automatic test_overflow();
        apply_reset();
        send_msg(18, 27'h40);
        tick();
        send_msg(1, 27'h7FFFFFF);
        tick();
        pulse_par(162'h3);
        set_exp(27'h40, 162'h3);
        collect(0);
        tests++; if (n_got != 24) begin fails++; $display("FAIL ovf_count got %0d want 24", n_got); end
        for (int i = 0; i < 24; i++) begin
            tests++; if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL ovf_word%0d got %h want %h", i + 1, got_w[i], exp_w[i]); end
        end
        tests++; if (bus.err_ovf !== ERR_EN) begin fails++; $display("FAIL ovf_flag got %b want %b", bus.err_ovf, ERR_EN); end
        tests++; if (bus.err_short !== 1'b0) begin fails++; $display("FAIL ovf_short_flag got %b want 0", bus.err_short); end
    endtask

    task automatic test_short();
        int seen;
        logic [161:0] p;
        p = {27'h1234567, 27'h0, 27'h0, 27'h0, 27'h0, 27'h7654321};
        apply_reset();
        send_msg(10, 27'h300);
        tick();
        pulse_par(162'hFFFF);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.cw_valid !== 1'b0) seen++;
            tick();
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL short_no_valid got %0d valid cycles want 0", seen); end
        tests++; if (bus.err_short !== ERR_EN) begin fails++; $display("FAIL short_flag got %b want %b", bus.err_short, ERR_EN); end
        tests++; if (bus.msg_ready !== 1'b1) begin fails++; $display("FAIL short_idle got msg_ready=%b want 1", bus.msg_ready); end
        send_msg(18, 27'h500);
        repeat (3) tick();
        pulse_par(p);
        set_exp(27'h500, p);
        collect(0);
        tests++; if (n_got != 24) begin fails++; $display("FAIL short_next_count got %0d want 24", n_got); end
        for (int i = 0; i < 24; i++) begin
            tests++; if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL short_next_word%0d got %h want %h", i + 1, got_w[i], exp_w[i]); end
        end
        tests++; if (bus.err_short !== ERR_EN) begin fails++; $display("FAIL short_sticky got %b want %b", bus.err_short, ERR_EN); end
    endtask

    task automatic test_reset_mid_send();
        int seen;
        apply_reset();
        send_msg(18, 27'h600);
        repeat (2) tick();
        bus.cw_ready = 1'b1;
        pulse_par(162'h5);
        repeat (6) tick();
        tests++; if (bus.cw_data !== 27'h606) begin fails++; $display("FAIL rst_mid_word7 got %h want 606", bus.cw_data); end
        rst = 1'b0;
        #1;
        tests++; if (bus.cw_valid !== 1'b0 || bus.cw_sop !== 1'b0 || bus.cw_eop !== 1'b0 || bus.cw_data !== 27'h0) begin
            fails++; $display("FAIL rst_mid_outputs got v=%b sop=%b eop=%b d=%h want 0", bus.cw_valid, bus.cw_sop, bus.cw_eop, bus.cw_data); end
        tests++; if (bus.msg_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_msg_ready got %b want 1", bus.msg_ready); end
        repeat (2) tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.cw_valid !== 1'b0) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL rst_mid_no_reemit got %0d valid cycles want 0", seen); end
        send_msg(18, 27'h700);
        repeat (2) tick();
        pulse_par(162'h9);
        set_exp(27'h700, 162'h9);
        collect(0);
        tests++; if (n_got != 24 || cycles_used != 24) begin fails++; $display("FAIL rst_mid_count got %0d words in %0d cycles want 24/24", n_got, cycles_used); end
        for (int i = 0; i < 24; i++) begin
            tests++; if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL rst_mid_word%0d got %h want %h", i + 1, got_w[i], exp_w[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_parity_order();
        test_overflow();
        test_short();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ldpc_cw_serializer.md
# ldpc_cw_serializer

Downstream stage of the LDPC encoder: assembles the systematic codeword for the 648-bit, Z=27, rate-3/4 code and streams it out in 27-bit words. It buffers the message words presented to the encoder, captures the encoder's 162-bit parity result {p1, p2}, and emits the message words followed by six parity words under valid/ready flow control. It sits between the encoder output and the modulator/interleaver input.

## Interface
- MSG_WORDS, default 18: message words per codeword (k = 27·MSG_WORDS); legal range 1..26.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- msg_valid  in  1  message word strobe; same stream and timing as the encoder's data input.
- msg_data  in  27  message word; bit 26 is first in codeword order.
- msg_ready  out  1  high in IDLE and COLLECT.
- par_valid  in  1  single-cycle strobe: par_data holds the encoder's parity result.
- par_data  in  162  parity {p1[26:0], p2[134:0]}; bits 161:135 are p1.
- cw_valid  out  1  cw_data holds a valid codeword word.
- cw_ready  in  1  downstream accepts the word when cw_valid && cw_ready.
- cw_data  out  27  codeword word.
- cw_sop  out  1  qualifies the first word of a codeword.
- cw_eop  out  1  qualifies the last word of a codeword.
- err_ovf  out  1  sticky: a message word was dropped.
- err_short  out  1  sticky: parity arrived before MSG_WORDS message words.

## Operation
- Single-codeword buffer: msg_buf of MSG_WORDS×27 bits, par_buf of 162 bits, word counter of width $clog2(MSG_WORDS+6).
- FSM states and transitions:
  - IDLE: on msg_valid, write word 0 and go to COLLECT with cnt=1.
  - COLLECT: each msg_valid writes msg_buf[cnt] and increments cnt. When cnt reaches MSG_WORDS, go to WAIT_PAR.
  - WAIT_PAR: on par_valid, capture par_data, set cnt=0 and go to SEND.
  - SEND: output word cnt, which is msg_buf[cnt] for cnt < MSG_WORDS, otherwise parity word j = cnt−MSG_WORDS.
    - Parity words are taken from par_data in this order: bits 161:135 (p1), 134:108, 107:81, 80:54, 53:27, 26:0.
    - Each accepted handshake increments cnt.
    - When the word with cnt = MSG_WORDS+5 is accepted, go to IDLE.
- cw_sop is high for cnt=0 in SEND; cw_eop is high for cnt=MSG_WORDS+5.
- cw_data, cw_sop and cw_eop are held stable while cw_valid && !cw_ready.
- msg_valid in WAIT_PAR or SEND: the word is dropped and err_ovf is set.
- par_valid in IDLE or SEND: ignored, no error.
- par_valid in COLLECT: the partial message is discarded, err_short is set, and the FSM goes to IDLE.
- msg_valid and par_valid in the same COLLECT cycle: par_valid wins and the word is discarded.
- The last message word and par_valid can never coincide in COLLECT: the parity follows the last message word by the encoder's pipeline latency.

## Timing
- Reset values: cw_valid=0, cw_sop=0, cw_eop=0, cw_data=0, err_ovf=0, err_short=0, msg_ready=1. The FSM resets to IDLE and cnt to 0.
- Reset asserted mid-codeword aborts it immediately. After reset release, no partial word is re-emitted.
- par_valid at edge t puts the FSM in SEND, with cw_valid=1 and cw_sop=1, from t+1 (one-cycle latency).
- With cw_ready held high, exactly MSG_WORDS+6 consecutive cw_valid cycles are produced (24 at the default).
- All outputs are registered. msg_ready is a decode of the registered state.
- The next codeword is accepted from the cycle after the cw_eop handshake.

## Configuration
- LDPC_SER_ERR_EN defined: err_ovf and err_short behave as specified. They are sticky until reset.
- LDPC_SER_ERR_EN undefined: err_ovf and err_short are tied to 0 and their logic is not compiled. Dropping and discard behaviour is unchanged.

## Test plan
- Nominal: drive 18 words 27'h0000001..27'h0000012, then par_valid with par_data = 162'h1 after 6 idle cycles, cw_ready=1 -> cw_valid from the next cycle.
  - Words 1..18 are output first.
  - Then the parity words 0,0,0,0,0,1 follow.
  - sop is on word 1 and eop on the final 1; 24 cycles total.
- Backpressure: same stimulus with cw_ready toggling 1,0,0,1 repeating -> the same 24 words in the same order, each held stable while stalled, with no duplicates.
- Parity order: par_data bits 161:135 = 27'h5A5A5A5 and bits 26:0 = 27'h2A2A2A2, all others 0 -> word 19 = 27'h5A5A5A5, word 24 = 27'h2A2A2A2.
- Overflow: a 19th msg_valid in WAIT_PAR -> it is not output and err_ovf=1 (0 if LDPC_SER_ERR_EN is undefined); the codeword is unaffected.
- Short message: par_valid after 10 words -> err_short=1, no cw_valid, FSM in IDLE. The following full message encodes correctly.
- Reset mid-SEND: assert rst at word 7 -> all outputs 0 at once. After release, a new full message produces a correct 24-word codeword.
